// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline package for the hazard controller and stage registers.
// Holds the multicycle FSM encoding, the default MEM timeout, and the
// packed stall/flush bundles that the top-level decode fills in.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_e;

  localparam int unsigned MEM_TIMEOUT_DEF = 255;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } stall_t;

  typedef struct packed {
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } flush_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Tracks consecutive data-memory wait cycles and raises a sticky error once
// the run length reaches MEM_TIMEOUT.
// Ports: clk, rst_n (async low), mem_wait (MEM stalled this cycle),
//        mem_err (sticky timeout flag, cleared only by reset).
module mem_wait_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_wait,
  output logic mem_err
);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_err_q,  mem_err_d;

  always_comb begin
    wait_cnt_d = 8'd0;
    if (mem_wait)
      wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
    // Flag on the edge where the count lands on the limit; sticky after.
    mem_err_d = mem_err_q | (mem_wait & (wait_cnt_d == 8'(MEM_TIMEOUT)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 8'd0;
      mem_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: resolves MEM waits, multicycle mul/div waits,
// taken branches and load-use hazards into per-stage stall/flush controls.
// Ports: clk, rst_n (async low); ID source regs/uses; EX load/rd, branch,
//        mul/div start/done; MEM req/ready; stall and flush per stage;
//        mem_err (sticky MEM timeout); stall_cycles (pc_stall cycle count).
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_MemRead,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        ex_md_start,
  input  logic        ex_md_done,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_stall,
  output logic        exmem_stall,
  output logic        memwb_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        mem_err,
  output logic [31:0] stall_cycles
);

  hz_state_e   state_q, state_d;
  logic        mem_wait, load_use, md_wait;
  stall_t      stall;
  flush_t      flush;
  logic [31:0] stall_cycles_q;

  assign mem_wait = mem_req & ~mem_ready;
  // Load-use is stateless: after one bubble the load has moved to MEM.
  assign load_use = ex_MemRead & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) |
                     (id_use_rs2 & (id_rs2 == ex_rd)));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // FSM: next state. A done that lands during a MEM wait is held off until
  // the wait clears; done is a level so it is still present then.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (ex_md_start & ~ex_md_done) state_d = MD_WAIT;
      MD_WAIT: if (ex_md_done & ~mem_wait)    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM: outputs. The start cycle already stalls, before MD_WAIT is entered.
  always_comb begin
    md_wait = 1'b0;
    unique case (state_q)
      RUN:     md_wait = ex_md_start & ~ex_md_done;
      MD_WAIT: md_wait = ~ex_md_done;
      default: md_wait = 1'b0;
    endcase
  end

  // Priority decode; each branch stalls upstream and bubbles the first
  // stage downstream of the hold point, so no register is both held and
  // flushed.
  always_comb begin
    stall = '0;
    flush = '0;
    if (mem_wait) begin
      stall = '{pc: 1'b1, ifid: 1'b1, idex: 1'b1, exmem: 1'b1, memwb: 1'b0};
      flush.memwb = 1'b1;
    end else if (md_wait) begin
      stall = '{pc: 1'b1, ifid: 1'b1, idex: 1'b1, exmem: 1'b0, memwb: 1'b0};
      flush.exmem = 1'b1;
    end else if (ex_branch_taken) begin
      flush.ifid = 1'b1;
      flush.idex = 1'b1;
    end else if (load_use) begin
      stall.pc   = 1'b1;
      stall.ifid = 1'b1;
      flush.idex = 1'b1;
    end
  end

  assign pc_stall    = stall.pc;
  assign ifid_stall  = stall.ifid;
  assign idex_stall  = stall.idex;
  assign exmem_stall = stall.exmem;
  assign memwb_stall = stall.memwb;
  assign ifid_flush  = flush.ifid;
  assign idex_flush  = flush.idex;
  assign exmem_flush = flush.exmem;
  assign memwb_flush = flush.memwb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        stall_cycles_q <= 32'd0;
    else if (stall.pc) stall_cycles_q <= stall_cycles_q + 32'd1;
  end

  assign stall_cycles = stall_cycles_q;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_wait (mem_wait),
    .mem_err  (mem_err)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a rule-level reference model that is
// compared against the DUT every cycle, plus literal scenario expectations.
module tb_hazard_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_use_rs1 = 0, id_use_rs2 = 0, ex_MemRead = 0;
  logic        ex_branch_taken = 0, ex_md_start = 0, ex_md_done = 0;
  logic        mem_req = 0, mem_ready = 0;
  logic        pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_err;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_MemRead(ex_MemRead), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .ex_md_start(ex_md_start), .ex_md_done(ex_md_done),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .exmem_stall(exmem_stall), .memwb_stall(memwb_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  // Reference model state: is a mul/div still outstanding, length of the
  // current MEM wait run, sticky error, and the stall cycle tally.
  logic        m_busy;
  int          m_run;
  logic        m_err;
  logic [31:0] m_stalls;

  // Control vector order:
  // {pc,ifid,idex,exmem,memwb stall, ifid,idex,exmem,memwb flush}
  function automatic logic [8:0] exp_ctl();
    logic mw, lu, mdw;
    mw  = mem_req && !mem_ready;
    lu  = ex_MemRead && ex_rd != 0 &&
          ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    mdw = m_busy ? !ex_md_done : (ex_md_start && !ex_md_done);
    if (mw)                   return 9'b11110_0001;
    else if (mdw)             return 9'b11100_0010;
    else if (ex_branch_taken) return 9'b00000_1100;
    else if (lu)              return 9'b11000_0100;
    else                      return 9'b00000_0000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_run    <= 0;
      m_err    <= 1'b0;
      m_stalls <= 32'd0;
    end else begin
      if (!m_busy && ex_md_start && !ex_md_done) m_busy <= 1'b1;
      if (m_busy && ex_md_done && !(mem_req && !mem_ready)) m_busy <= 1'b0;
      if (mem_req && !mem_ready) begin
        m_run <= (m_run >= 255) ? 255 : m_run + 1;
        if (m_run + 1 >= int'(TO)) m_err <= 1'b1;
      end else begin
        m_run <= 0;
      end
      if (exp_ctl() >= 9'b10000_0000) m_stalls <= m_stalls + 32'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("ctl_vs_model", 32'({pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
                              ifid_flush, idex_flush, exmem_flush, memwb_flush}),
        32'(exp_ctl()));
    chk("mem_err_vs_model", 32'(mem_err), 32'(m_err));
    chk("stall_cycles_vs_model", stall_cycles, m_stalls);
  end

  task automatic clr();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_MemRead = 0; ex_branch_taken = 0; ex_md_start = 0; ex_md_done = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  logic [31:0] base;

  initial begin
    // Reset state
    #2;
    chk("reset_stall_cycles", stall_cycles, 32'd0);
    chk("reset_mem_err", 32'(mem_err), 32'd0);
    chk("reset_pc_stall", 32'(pc_stall), 32'd0);
    @(posedge clk); #3; rst_n = 1'b1;
    next();

    // Load-use on rs1
    ex_MemRead = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    @(negedge clk);
    chk("lu_pc_stall", 32'(pc_stall), 32'd1);
    chk("lu_ifid_stall", 32'(ifid_stall), 32'd1);
    chk("lu_idex_flush", 32'(idex_flush), 32'd1);
    chk("lu_idex_stall", 32'(idex_stall), 32'd0);
    next(); clr();
    @(negedge clk);
    chk("lu_count", stall_cycles, 32'd1);
    next();

    // Load-use on rs2 only
    ex_MemRead = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1; id_rs1 = 9;
    @(negedge clk);
    chk("lu2_pc_stall", 32'(pc_stall), 32'd1);
    next(); clr();

    // x0 rule
    ex_MemRead = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    @(negedge clk);
    chk("x0_all_zero", 32'({pc_stall, ifid_stall, idex_stall, idex_flush, ifid_flush}), 32'd0);
    next(); clr();

    // Branch wins over load-use
    ex_MemRead = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; ex_branch_taken = 1;
    @(negedge clk);
    chk("br_flushes", 32'({ifid_flush, idex_flush}), 32'd3);
    chk("br_pc_stall", 32'(pc_stall), 32'd0);
    next(); clr();

    // Mul/div: start pulse, done 4 cycles later
    base = stall_cycles;
    ex_md_start = 1;
    @(negedge clk);
    chk("md_start_exmem_flush", 32'(exmem_flush), 32'd1);
    next(); ex_md_start = 0;
    for (int i = 0; i < 3; i++) next();
    ex_md_done = 1;
    @(negedge clk);
    chk("md_done_pc_stall", 32'(pc_stall), 32'd0);
    next(); ex_md_done = 0;
    @(negedge clk);
    chk("md_stall_delta", stall_cycles - base, 32'd4);
    chk("md_back_in_run", 32'(pc_stall), 32'd0);
    next();

    // Memory wait during MD_WAIT, done arriving in wait cycle 2
    ex_md_start = 1; next(); ex_md_start = 0;
    mem_req = 1; mem_ready = 0;
    for (int i = 1; i <= 3; i++) begin
      if (i >= 2) ex_md_done = 1;
      @(negedge clk);
      chk("mw_p1_outputs", 32'({pc_stall, exmem_stall, memwb_flush, exmem_flush}), 32'b1110);
      next();
    end
    mem_ready = 1;
    @(negedge clk);
    chk("mw_release_no_stall", 32'(pc_stall), 32'd0);
    next(); clr();
    @(negedge clk);
    chk("mw_fsm_run", 32'(pc_stall), 32'd0);
    chk("mw_no_err", 32'(mem_err), 32'd0);
    next();

    // Timeout: MEM_TIMEOUT=4, wait held 6 cycles, then async reset
    mem_req = 1; mem_ready = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("to_mem_err", 32'(mem_err), (i >= 5) ? 32'd1 : 32'd0);
      next();
    end
    #2; rst_n = 1'b0; #1;
    chk("arst_mem_err", 32'(mem_err), 32'd0);
    chk("arst_stall_cycles", stall_cycles, 32'd0);
    chk("arst_pc_stall_comb", 32'(pc_stall), 32'd1);
    clr();
    @(posedge clk); #3; rst_n = 1'b1;
    next(); next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
